// File: rtl/reg_file_pkg.sv
// Shared types and default geometry for the DECODE-stage register file
// and the hazard unit that consumes its busy flags.
package reg_file_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, with lookups
// masked when the same register is being written back this cycle.
module reg_scoreboard #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] look_a,
   input  logic [ADDR_W-1:0] look_b,
   input  logic              bypass,
   input  logic [ADDR_W-1:0] bypass_addr,
   output logic              busy_a,
   output logic              busy_b
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy;

   // The set is written last so it wins a same-edge collision with a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (clr) busy[clr_addr] <= 1'b0;
         if (set) busy[set_addr] <= 1'b1;
      end
   end

   assign busy_a = busy[look_a] & ~(bypass & (bypass_addr == look_a));
   assign busy_b = busy[look_b] & ~(bypass & (bypass_addr == look_b));
endmodule

// File: rtl/reg_file.sv
// DECODE register file: two combinational read ports with writeback bypass,
// one write port, a post-reset sequential clear and a busy scoreboard.
//
// state | meaning
// CLEAR | zeroing mem[idx] one entry per edge; writes/reservations ignored
// RUN   | normal operation, ready=1
module reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              regwrite,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] writedata,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic              reserve,
   input  logic [ADDR_W-1:0] reserve_addr,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              busy_a,
   output logic              busy_b,
   output logic              ready
);
   localparam int DEPTH = 2**ADDR_W;

   state_t            state, state_next;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              idx_last;
   logic              wr_ok;
   logic              set_ok;
   logic              sb_busy_a, sb_busy_b;

   assign idx_last = (idx == {ADDR_W{1'b1}});
   assign ready    = (state == RUN);
   assign wr_ok    = regwrite & ~(ZERO_REG & (rd == '0));
   assign set_ok   = ready & reserve & ~(ZERO_REG & (reserve_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (idx_last) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                 idx <= '0;
      else if (state == CLEAR) idx <= idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) mem[idx] <= '0;
         else if (wr_ok)     mem[rd]  <= writedata;
      end
   end

   // Reads: hidden until cleared, hardwired zero, then bypass, then storage.
   always_comb begin
      A = '0;
      B = '0;
      if (ready) begin
         if (ZERO_REG && rs == '0)         A = '0;
         else if (regwrite && rd == rs)    A = writedata;
         else                              A = mem[rs];
         if (ZERO_REG && rt == '0)         B = '0;
         else if (regwrite && rd == rt)    B = writedata;
         else                              B = mem[rt];
      end
   end

   reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .set         (set_ok),
      .set_addr    (reserve_addr),
      .clr         (ready & regwrite),
      .clr_addr    (rd),
      .look_a      (rs),
      .look_b      (rt),
      .bypass      (regwrite),
      .bypass_addr (rd),
      .busy_a      (sb_busy_a),
      .busy_b      (sb_busy_b)
   );

   assign busy_a = ready & sb_busy_a;
   assign busy_b = ready & sb_busy_b;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus random traffic checked every
// cycle against an array-based model; a small instance covers geometry.
module tb_reg_file;
   logic        clk;
   logic        rst, regwrite, reserve;
   logic [4:0]  rd, rs, rt, reserve_addr;
   logic [31:0] writedata, a_out, b_out;
   logic        busy_a, busy_b, ready;

   logic        rst_s, regwrite_s, reserve_s;
   logic [2:0]  rd_s, rs_s, rt_s, reserve_addr_s;
   logic [15:0] writedata_s, a_s, b_s;
   logic        busy_a_s, busy_b_s, ready_s;

   int vectors;
   int miscompares;

   reg_file u_dut (
      .clk(clk), .rst(rst), .regwrite(regwrite), .rd(rd), .writedata(writedata),
      .rs(rs), .rt(rt), .reserve(reserve), .reserve_addr(reserve_addr),
      .A(a_out), .B(b_out), .busy_a(busy_a), .busy_b(busy_b), .ready(ready)
   );

   reg_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) u_small (
      .clk(clk), .rst(rst_s), .regwrite(regwrite_s), .rd(rd_s), .writedata(writedata_s),
      .rs(rs_s), .rt(rt_s), .reserve(reserve_s), .reserve_addr(reserve_addr_s),
      .A(a_s), .B(b_s), .busy_a(busy_a_s), .busy_b(busy_b_s), .ready(ready_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: after a reset everything reads as zero; the only visible effect
   // of the clear sequence is the number of cycles until ready.
   logic [31:0] m_mem [32];
   bit          m_busy [32];
   int          m_clear_left;
   bit          m_valid;

   initial begin
      m_valid = 1'b0;
      m_clear_left = 32;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
         end
         m_clear_left = 32;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_clear_left > 0) begin
            m_clear_left--;
         end else begin
            if (regwrite) begin
               if (rd != 5'd0) m_mem[rd] = writedata;
               m_busy[rd] = 1'b0;
            end
            if (reserve && reserve_addr != 5'd0) m_busy[reserve_addr] = 1'b1;
         end
      end
   end

   function automatic logic [31:0] exp_read(logic [4:0] addr);
      if (m_clear_left != 0) return 32'h0;
      if (addr == 5'd0) return 32'h0;
      if (regwrite && rd == addr) return writedata;
      return m_mem[addr];
   endfunction

   function automatic logic exp_busy(logic [4:0] addr);
      if (m_clear_left != 0) return 1'b0;
      return m_busy[addr] && !(regwrite && rd == addr);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_ready",  {31'h0, ready},  {31'h0, (m_clear_left == 0)});
         chk("cyc_A",      a_out,           exp_read(rs));
         chk("cyc_B",      b_out,           exp_read(rt));
         chk("cyc_busy_a", {31'h0, busy_a}, {31'h0, exp_busy(rs)});
         chk("cyc_busy_b", {31'h0, busy_b}, {31'h0, exp_busy(rt)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regwrite = 1'b0; rd = 5'd0; writedata = 32'h0;
      reserve = 1'b0; reserve_addr = 5'd0;
   endtask

   task automatic ready_latency(string name, int expected);
      int cnt;
      cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
         cnt++;
         tick();
      end
      chk(name, 32'(cnt), 32'(expected));
   endtask

   initial begin
      int cnt;
      vectors = 0;
      miscompares = 0;
      idle();
      rs = 5'd5; rt = 5'd31;
      rst_s = 1'b0; regwrite_s = 1'b0; reserve_s = 1'b0;
      rd_s = 3'd0; rs_s = 3'd0; rt_s = 3'd0; reserve_addr_s = 3'd0; writedata_s = 16'h0;

      // Reset then idle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'h0, ready}, 32'h0);
      chk("rst_A", a_out, 32'h0);
      chk("rst_B", b_out, 32'h0);
      chk("rst_busy_a", {31'h0, busy_a}, 32'h0);
      ready_latency("ready_latency", 32);
      chk("idle_A", a_out, 32'h0);
      chk("idle_B", b_out, 32'h0);

      // Write with same-cycle bypass, then stored value
      rs = 5'd7; regwrite = 1'b1; rd = 5'd7; writedata = 32'hDEADBEEF;
      #1 chk("bypass_A", a_out, 32'hDEADBEEF);
      tick();
      idle();
      #1 chk("stored_A", a_out, 32'hDEADBEEF);

      // Register zero
      rs = 5'd0; regwrite = 1'b1; rd = 5'd0; writedata = 32'h12345678;
      #1 chk("zero_bypass_A", a_out, 32'h0);
      tick();
      idle();
      #1 chk("zero_stored_A", a_out, 32'h0);
      reserve = 1'b1; reserve_addr = 5'd0;
      tick();
      idle();
      #1 chk("zero_busy_a", {31'h0, busy_a}, 32'h0);

      // Scoreboard
      rs = 5'd9; reserve = 1'b1; reserve_addr = 5'd9;
      #1 chk("reserve_no_comb", {31'h0, busy_a}, 32'h0);
      tick();
      idle();
      #1 chk("reserved_busy", {31'h0, busy_a}, 32'h1);
      regwrite = 1'b1; rd = 5'd9; writedata = 32'h1;
      #1 chk("wb_mask_busy", {31'h0, busy_a}, 32'h0);
      tick();
      idle();
      #1 chk("wb_cleared_busy", {31'h0, busy_a}, 32'h0);
      regwrite = 1'b1; rd = 5'd9; writedata = 32'h55;
      reserve = 1'b1; reserve_addr = 5'd9;
      tick();
      idle();
      #1 chk("set_wins_busy", {31'h0, busy_a}, 32'h1);
      chk("set_wins_A", a_out, 32'h55);

      // Reset mid-RUN, then mid-CLEAR
      regwrite = 1'b1; rd = 5'd3; writedata = 32'hA5A5A5A5;
      tick();
      idle();
      reserve = 1'b1; reserve_addr = 5'd4;
      tick();
      idle();
      rs = 5'd3; rt = 5'd4;
      #1 chk("pre_rst_A", a_out, 32'hA5A5A5A5);
      chk("pre_rst_busy_b", {31'h0, busy_b}, 32'h1);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      regwrite = 1'b1; rd = 5'd3; writedata = 32'hFFFFFFFF;
      tick();
      rst = 1'b0;
      idle();
      #1 chk("mid_rst_ready", {31'h0, ready}, 32'h0);
      chk("mid_rst_busy_b", {31'h0, busy_b}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         regwrite = 1'b1; rd = 5'd3; writedata = 32'h0BADF00D;
         reserve = 1'b1; reserve_addr = 5'd4;
         tick();
      end
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ready_latency("clear_restart_latency", 32);
      chk("post_clear_A", a_out, 32'h0);
      chk("post_clear_busy_b", {31'h0, busy_b}, 32'h0);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 299) == 0);
         regwrite     = ($urandom_range(0, 2) == 0);
         reserve      = ($urandom_range(0, 2) == 0);
         writedata    = $urandom;
         rd           = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         reserve_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         rs           = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         rt           = 5'($urandom_range(0, 31));
         tick();
      end
      rst = 1'b0;
      idle();
      cnt = 0;
      while (ready !== 1'b1 && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("random_end_ready", {31'h0, ready}, 32'h1);

      // Smaller geometry
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0;
      cnt = 0;
      while (ready_s !== 1'b1 && cnt < 100) begin
         cnt++;
         tick();
      end
      chk("small_ready_latency", 32'(cnt), 32'd8);
      regwrite_s = 1'b1; rd_s = 3'd7; writedata_s = 16'hFFFF; rs_s = 3'd7; rt_s = 3'd0;
      #1 chk("small_bypass_A", 32'(a_s), 32'h0000FFFF);
      tick();
      regwrite_s = 1'b0; writedata_s = 16'h0; rt_s = 3'd7;
      #1 chk("small_stored_A", 32'(a_s), 32'h0000FFFF);
      chk("small_stored_B", 32'(b_s), 32'h0000FFFF);
      rs_s = 3'd0;
      #1 chk("small_zero_A", 32'(a_s), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/reg_file.md
# reg_file

Parametrised general-purpose register file for the DECODE stage of the MIPS pipeline: two combinational read ports (A/B), one clocked write port, hardwired-zero register 0, and same-cycle write-to-read bypass. Adds a synchronous sequential clear after reset and a per-register busy scoreboard so DECODE can detect read-after-write hazards on in-flight destinations. Sits between the instruction decoder (rs/rt/rd fields) and the ID/EX pipeline register; WRITEBACK drives the write port.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes/reservations
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- regwrite  input  1  write enable from WRITEBACK
- rd  input  ADDR_W  write address
- writedata  input  DATA_W  write data
- rs  input  ADDR_W  read address, port A
- rt  input  ADDR_W  read address, port B
- reserve  input  1  mark reserve_addr as pending (instruction issued)
- reserve_addr  input  ADDR_W  destination being reserved
- A  output  DATA_W  read data, port A
- B  output  DATA_W  read data, port B
- busy_a  output  1  register rs has a pending write
- busy_b  output  1  register rt has a pending write
- ready  output  1  clear sequence done; block accepts writes/reservations

## Operation
- FSM states: CLEAR, RUN. rst at an edge → CLEAR, clear index idx=0, all busy bits 0, ready=0.
- CLEAR: each edge writes mem[idx]=0, idx++; on the edge writing idx=DEPTH-1 → RUN, ready=1. regwrite and reserve ignored in CLEAR.
- RUN: on edge, if regwrite and not (ZERO_REG and rd==0): mem[rd]=writedata.
- Reads combinational. A = 0 if ready=0, else 0 if ZERO_REG and rs==0, else writedata if regwrite and rd==rs (bypass), else mem[rs]. B identical with rt.
- Scoreboard (RUN only): regwrite clears busy[rd]; reserve sets busy[reserve_addr]. Same edge, same address: set wins. Address 0 never set when ZERO_REG=1.
- Reserving an already-busy register: stays busy (single bit, no count). Write to non-busy register: legal, busy unchanged at 0.
- busy_a = busy[rs] and not (regwrite and rd==rs); same for busy_b with rt. Both 0 while ready=0.
- Reset values: A=0, B=0, busy_a=0, busy_b=0, ready=0.

## Timing
- Read latency 0 (combinational from rs/rt/regwrite/rd/writedata).
- Write latency 1: data visible from mem on the cycle after the edge; visible same cycle via bypass.
- ready rises DEPTH edges after the last edge with rst=1 (32 for defaults).
- rst asserted mid-CLEAR or mid-RUN: restarts CLEAR at idx 0, discards pending scoreboard state; writes on that edge are dropped.
- No combinational path from reserve/reserve_addr to any output.

## Structure
- Package reg_file_pkg: state enum (CLEAR, RUN), default DATA_W/ADDR_W constants, shared with the decoder's hazard unit.
- Sub-module reg_scoreboard: DEPTH busy bits, set/clear ports, two lookup outputs with bypass masking; instantiated once.
- Storage as a DEPTH×DATA_W array; clear FSM and idx counter in the top.

## Test plan
- Reset then idle: rst 1 cycle → ready=0 for exactly 32 cycles, then 1; A=B=0 for rs=5, rt=31.
- Write/read: regwrite rd=7 writedata=0xDEADBEEF, rs=7 same cycle → A=0xDEADBEEF (bypass); next cycle regwrite=0 → A still 0xDEADBEEF.
- Zero register: write rd=0 data 0x12345678 → A=0 for rs=0; reserve addr 0 → busy_a stays 0.
- Scoreboard: reserve addr 9 → next cycle busy_a=1 (rs=9); regwrite rd=9 → busy_a=0 same cycle, busy stays 0 after edge; simultaneous reserve 9 and regwrite rd=9 → busy_a=1 after edge.
- Reset mid-operation: write rd=3=0xA5A5A5A5, reserve 4, assert rst at cycle 10 of CLEAR/RUN → ready=0, busy cleared, after 32 cycles rs=3 reads 0.
- Parameter sweep: DATA_W=16, ADDR_W=3 → ready after 8 cycles; write rd=7=0xFFFF reads back 0xFFFF.
